// File: rtl/sysid_pkg.sv
// Shared types and constants for the sysid readback checker.
package sysid_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIdReq,
        StIdWait,
        StTsReq,
        StTsWait,
        StFin
    } sysid_state_e;

    localparam logic        SYSID_ADDR_ID    = 1'b0;
    localparam logic        SYSID_ADDR_TS    = 1'b1;
    localparam logic [31:0] SYSID_DEFAULT_ID = 32'hAAAAAAAA;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h53699D78;

endpackage

// File: rtl/sysid_checker.sv
// Reads sysid words 0 (ID) and 1 (timestamp) over Avalon-MM and compares them
// against the expected build values, with a per-read timeout.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

    sysid_state_e state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         pass_q, pass_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  cap_id_q, cap_id_d;
    logic [31:0]  cap_ts_q, cap_ts_d;

    logic        in_req;
    logic        in_ts;
    logic        in_xfer;
    logic        take;
    logic [15:0] cnt_inc;

    always_comb begin
        in_req  = (state_q == StIdReq) || (state_q == StTsReq);
        in_ts   = (state_q == StTsReq) || (state_q == StTsWait);
        in_xfer = in_req || (state_q == StIdWait) || (state_q == StTsWait);
        // Data is only accepted once the request has been taken, which also
        // covers a zero-latency responder answering in the accept cycle.
        take    = in_xfer && avm_readdatavalid && !(in_req && avm_waitrequest);
        cnt_inc = cnt_q + 16'd1;

        state_d   = state_q;
        cnt_d     = cnt_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;

        if (state_q == StIdle || state_q == StFin) begin
            if (start) begin
                state_d   = StIdReq;
                cnt_d     = '0;
                id_ok_d   = 1'b0;
                ts_ok_d   = 1'b0;
                timeout_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (take) begin
                if (in_ts) begin
                    cap_ts_d = avm_readdata;
                    ts_ok_d  = (avm_readdata == EXPECTED_TS);
                    state_d  = StFin;
                end else begin
                    cap_id_d = avm_readdata;
                    id_ok_d  = (avm_readdata == EXPECTED_ID);
                    state_d  = StTsReq;
                    cnt_d    = '0;
                end
            end else if (cnt_inc >= TimeoutLimit) begin
                timeout_d = 1'b1;
                state_d   = StFin;
            end else begin
                cnt_d = cnt_inc;
                if (in_req && !avm_waitrequest) begin
                    state_d = in_ts ? StTsWait : StIdWait;
                end
            end
        end

        pass_d = (state_d == StFin) && id_ok_d && ts_ok_d && !timeout_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= '0;
            cap_ts_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

    assign avm_read    = (state_q == StIdReq) || (state_q == StTsReq);
    assign avm_address = ((state_q == StTsReq) || (state_q == StTsWait)) ? SYSID_ADDR_TS
                                                                          : SYSID_ADDR_ID;
    assign busy        = (state_q != StIdle) && (state_q != StFin);
    assign done        = (state_q == StFin);
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker against a simple latency-1 Avalon responder model.
module tb_sysid_checker;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;

    int passes = 0;
    int total  = 0;

    // Responder configuration
    int          wait_cfg   = 0;
    bit          drop_ts    = 1'b0;
    logic [31:0] id_word    = 32'hAAAAAAAA;
    logic [31:0] ts_word    = 32'h53699D78;
    bit          stray      = 1'b0;
    logic [31:0] stray_data = 32'hAAAAAAAA;

    int          wait_cnt = 0;
    logic        rdv_q    = 1'b0;
    logic [31:0] rdata_q  = '0;

    logic [5:0]  first_snap;

    always #5 clock = ~clock;

    sysid_checker #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout          (timeout),
        .captured_id      (captured_id),
        .captured_ts      (captured_ts)
    );

    assign avm_waitrequest   = avm_read && (wait_cnt < wait_cfg);
    assign avm_readdatavalid = rdv_q | stray;
    assign avm_readdata      = stray ? stray_data : rdata_q;

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        rdv_q <= 1'b0;
        if (avm_read && !avm_waitrequest && !(avm_address && drop_ts)) begin
            rdv_q   <= 1'b1;
            rdata_q <= avm_address ? ts_word : id_word;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Pulses start, optionally re-pulses it at tick mid_at, and waits (bounded) for done.
    task automatic do_run(input int mid_at, output int lat, output bit stable);
        bit         hold;
        logic       addr;
        start = 1'b1;
        tick();
        start = 1'b0;
        first_snap = {done, pass, id_ok, ts_ok, timeout, busy};
        lat    = 1;
        stable = 1'b1;
        while (!done && lat < 40) begin
            if (lat == mid_at) start = 1'b1;
            hold = avm_read && avm_waitrequest;
            addr = avm_address;
            tick();
            start = 1'b0;
            lat++;
            if (hold && !(avm_read && avm_address == addr)) stable = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit stable;

        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_read", 32'(avm_read), 32'd0);
        chk("reset_capid", captured_id, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Nominal run, zero wait, latency 1
        do_run(-1, lat, stable);
        chk("nom_latency", 32'(lat), 32'd5);
        chk("nom_pass", 32'(pass), 32'd1);
        chk("nom_id_ok", 32'(id_ok), 32'd1);
        chk("nom_ts_ok", 32'(ts_ok), 32'd1);
        chk("nom_timeout", 32'(timeout), 32'd0);
        chk("nom_capid", captured_id, 32'hAAAAAAAA);
        chk("nom_capts", captured_ts, 32'h53699D78);

        // Wrong ID word
        id_word = 32'h12345678;
        do_run(-1, lat, stable);
        chk("badid_done", 32'(done), 32'd1);
        chk("badid_id_ok", 32'(id_ok), 32'd0);
        chk("badid_ts_ok", 32'(ts_ok), 32'd1);
        chk("badid_pass", 32'(pass), 32'd0);
        chk("badid_capid", captured_id, 32'h12345678);
        id_word = 32'hAAAAAAAA;

        // Three wait-states on every read
        wait_cfg = 3;
        do_run(-1, lat, stable);
        chk("wait_latency", 32'(lat), 32'd11);
        chk("wait_stable", 32'(stable), 32'd1);
        chk("wait_pass", 32'(pass), 32'd1);
        wait_cfg = 0;

        // Timestamp never answered
        drop_ts = 1'b1;
        do_run(-1, lat, stable);
        chk("to_latency", 32'(lat), 32'd11);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_read", 32'(avm_read), 32'd0);
        chk("to_pass", 32'(pass), 32'd0);
        chk("to_id_ok", 32'(id_ok), 32'd1);
        chk("to_ts_ok", 32'(ts_ok), 32'd0);
        drop_ts = 1'b0;

        // Start during busy is ignored; start in FIN clears flags and reruns
        do_run(2, lat, stable);
        chk("busy_start_latency", 32'(lat), 32'd5);
        chk("busy_start_pass", 32'(pass), 32'd1);
        do_run(-1, lat, stable);
        chk("rerun_cleared", 32'(first_snap), 32'b000001);
        chk("rerun_latency", 32'(lat), 32'd5);
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_capts", captured_ts, 32'h53699D78);

        // Reset while waiting for the ID word, then a stray readdatavalid
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("rst_capid", captured_id, 32'd0);
        chk("rst_capts", captured_ts, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_id_ok", 32'(id_ok), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
